timer_dev: RTL and testbench

- Programmable interval timer that sits on the device side of the CPU's processor bus (Pr bus).
- The system bridge decodes the address and drives this block's word address, write strobe, byte enables and write data. The block returns read data combinationally.
- The IRQ output wires to one bit of the CPU's HWInt[7:2].
- Three software-visible registers: CTRL, PRESET, COUNT. Two modes: one-shot and auto-reload.

---
 rtl/timer_pkg.sv | 40 ++++
 rtl/timer_dev.sv | 128 ++++++++++++
 tb/tb_timer_dev.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared constants and the byte-merge helper for the timer_dev block
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_CNT  = 2'd2;
  localparam logic [1:0] c_ST_INT  = 2'd3;

  localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] c_ADDR_PRESET = 2'd1;
  localparam logic [1:0] c_ADDR_COUNT  = 2'd2;
  localparam logic [1:0] c_ADDR_EXPIRY = 2'd3;

  localparam int c_CTRL_EN      = 0;
  localparam int c_CTRL_MODE_LO = 1;
  localparam int c_CTRL_MODE_HI = 2;
  localparam int c_CTRL_IM      = 3;

  localparam logic [1:0] c_MODE_ONESHOT = 2'd0;
  localparam logic [1:0] c_MODE_AUTO    = 2'd1;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_dev.sv
// ============================================================================
// Module   : timer_dev
// Brief    : Pr-bus interval timer (CTRL/PRESET/COUNT), one-shot or auto-reload.
//            Optional EXPIRY counter at Addr 3 under `TIMER_EXPIRY_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [3:0]  Be,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic [1:0]  r_state;
  logic        r_irq_flag;

  logic        w_en;
  logic        w_im;
  logic        w_auto;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_expire;
  logic        w_reload_int;
  logic [3:0]  w_ctrl_merged;
  logic [31:0] w_rd_expiry;

  assign w_en          = r_ctrl[c_CTRL_EN];
  assign w_im          = r_ctrl[c_CTRL_IM];
  assign w_auto        = (r_ctrl[c_CTRL_MODE_HI:c_CTRL_MODE_LO] == c_MODE_AUTO);
  assign w_wr_ctrl     = We && (Addr == c_ADDR_CTRL);
  assign w_wr_preset   = We && (Addr == c_ADDR_PRESET);
  assign w_expire      = (r_state == c_ST_CNT) && w_en && (r_count == 32'd0);
  assign w_reload_int  = (r_state == c_ST_INT) && w_auto;
  // Only byte 0 of CTRL holds implemented bits.
  assign w_ctrl_merged = Be[0] ? Din[3:0] : r_ctrl;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_ST_IDLE;
      r_count <= 32'd0;
    end else begin
      case (r_state)
        c_ST_IDLE: if (w_en) r_state <= c_ST_LOAD;
        c_ST_LOAD: begin
          r_count <= r_preset;
          r_state <= c_ST_CNT;
        end
        c_ST_CNT: begin
          if (!w_en)                  r_state <= c_ST_IDLE;
          else if (r_count == 32'd0)  r_state <= c_ST_INT;
          else                        r_count <= r_count - 32'd1;
        end
        default: r_state <= w_auto ? c_ST_LOAD : c_ST_IDLE;
      endcase
    end
  end

  // A software CTRL write overrides the one-shot auto-clear of En.
  always_ff @(posedge Clk) begin
    if (Reset)
      r_ctrl <= 4'd0;
    else if (w_wr_ctrl)
      r_ctrl <= w_ctrl_merged;
    else if ((r_state == c_ST_INT) && !w_auto)
      r_ctrl[c_CTRL_EN] <= 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      r_preset <= PRESET_RST;
    else if (w_wr_preset)
      r_preset <= byte_merge(r_preset, Din, Be);
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      r_irq_flag <= 1'b0;
    else if (w_expire)
      r_irq_flag <= 1'b1;
    else if (w_wr_ctrl || w_wr_preset || w_reload_int)
      r_irq_flag <= 1'b0;
  end

`ifdef TIMER_EXPIRY_CNT_EN
  logic [31:0] r_expiry;

  always_ff @(posedge Clk) begin
    if (Reset)
      r_expiry <= 32'd0;
    else if (We && (Addr == c_ADDR_EXPIRY) && (|Be))
      r_expiry <= 32'd0;
    else if (w_expire)
      r_expiry <= r_expiry + 32'd1;
  end

  assign w_rd_expiry = r_expiry;
`else
  assign w_rd_expiry = 32'd0;
`endif

  always_comb begin
    Dout = 32'd0;
    case (Addr)
      c_ADDR_CTRL:   Dout = {28'd0, r_ctrl};
      c_ADDR_PRESET: Dout = r_preset;
      c_ADDR_COUNT:  Dout = r_count;
      default:       Dout = w_rd_expiry;
    endcase
  end

  assign IRQ = w_im & r_irq_flag;

endmodule

`default_nettype wire

// File: tb/tb_timer_dev.sv
// ============================================================================
// Module   : tb_timer_dev
// Brief    : Directed self-checking bench for timer_dev with an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_dev;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic        We = 1'b0;
  logic [3:0]  Be = 4'd0;
  logic [31:0] Din = 32'd0;
  logic [31:0] Dout;
  logic        IRQ;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

`ifdef TIMER_EXPIRY_CNT_EN
  localparam bit HAS_EXP = 1'b1;
`else
  localparam bit HAS_EXP = 1'b0;
`endif

  timer_dev #(.PRESET_RST(32'd0)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Addr  (Addr),
    .We    (We),
    .Be    (Be),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #10 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
    push(tag, v);
    Addr = a;
    #1;
    pop_cmp(Dout);
  endtask

  task automatic chk_irq(input string tag, input logic v);
    push(tag, {31'd0, v});
    pop_cmp({31'd0, IRQ});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    Addr = a;
    Din  = d;
    Be   = be;
    We   = 1'b1;
    tick();
    We   = 1'b0;
    Be   = 4'd0;
  endtask

  initial begin
    // Reset
    Reset = 1'b1;
    ticks(2);
    Reset = 1'b0;
    chk_reg("rst_ctrl", 2'd0, 32'd0);
    chk_reg("rst_preset", 2'd1, 32'd0);
    chk_reg("rst_count", 2'd2, 32'd0);
    chk_irq("rst_irq", 1'b0);
    ticks(3);
    chk_reg("idle_count_hold", 2'd2, 32'd0);

    // One-shot: PRESET=5, IRQ rises after e8
    wr(2'd1, 32'd5, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i >= 6) chk_irq($sformatf("os_irq_e%0d", i), i == 8);
    end
    tick();
    chk_reg("os_ctrl_after", 2'd0, 32'h8);
    chk_irq("os_irq_hold1", 1'b1);
    ticks(4);
    chk_irq("os_irq_hold2", 1'b1);
    chk_reg("os_count_zero", 2'd2, 32'd0);
    wr(2'd1, 32'd5, 4'hF);
    chk_irq("os_irq_clr", 1'b0);

    // Auto-reload: PRESET=2, period 5
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_irq($sformatf("ar_irq_e%0d", i), (i % 5) == 0);
      if ((i % 5) >= 2) chk_reg($sformatf("ar_count_e%0d", i), 2'd2, 32'(4 - (i % 5)));
    end
    wr(2'd0, 32'h0, 4'hF);
    ticks(4);
    chk_irq("ar_stopped", 1'b0);

    // Masked: flag sets but IRQ stays low
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_irq($sformatf("mask_irq_e%0d", i), 1'b0);
    end
    chk_reg("mask_ctrl_en_clr", 2'd0, 32'h0);

    // Pause mid-count, then reload
    wr(2'd0, 32'h1, 4'hF);
    ticks(3);
    chk_reg("pause_count_before", 2'd2, 32'd2);
    wr(2'd0, 32'h0, 4'hF);
    ticks(3);
    chk_reg("pause_count_frozen", 2'd2, 32'd1);
    wr(2'd0, 32'h1, 4'hF);
    ticks(2);
    chk_reg("reenable_reload", 2'd2, 32'd3);
    wr(2'd0, 32'h0, 4'hF);
    ticks(2);
    chk_reg("stop_count", 2'd2, 32'd2);

    // Byte enables, read-only COUNT, CTRL upper bits
    wr(2'd1, 32'h11223344, 4'hF);
    wr(2'd1, 32'hAABBCCDD, 4'b0101);
    chk_reg("be_merge", 2'd1, 32'h11BB33DD);
    wr(2'd2, 32'hFFFFFFFF, 4'hF);
    chk_reg("count_ro", 2'd2, 32'd2);
    wr(2'd0, 32'hFFFFFFF0, 4'hF);
    chk_reg("ctrl_upper_ignored", 2'd0, 32'h0);

    // EXPIRY register (reads 0 when the feature is absent)
    wr(2'd3, 32'hFFFFFFFF, 4'hF);
    chk_reg("exp_clear0", 2'd3, 32'd0);
    wr(2'd1, 32'd0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      wr(2'd0, 32'h9, 4'hF);
      ticks(5);
    end
    chk_reg("exp_three", 2'd3, HAS_EXP ? 32'd3 : 32'd0);
    wr(2'd3, 32'h0, 4'b0010);
    chk_reg("exp_clear1", 2'd3, 32'd0);

    // Reset mid-count
    wr(2'd1, 32'd10, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    ticks(8);
    chk_reg("midrst_count4", 2'd2, 32'd4);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_reg("midrst_count", 2'd2, 32'd0);
    chk_reg("midrst_ctrl", 2'd0, 32'd0);
    chk_reg("midrst_preset", 2'd1, 32'd0);
    chk_irq("midrst_irq", 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_irq($sformatf("midrst_noirq_%0d", i), 1'b0);
    end

    if (sb.size() != 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
